// File: rtl/function_3bit_solver_if.sv
// Request/stream bundle for the 3-input function solver: sweep control in,
// matching vectors out over valid/ready, plus the final mask and count.
interface function_3bit_solver_if #(
   parameter int NVARS = 3,
   parameter int CNT_W = 4
);
   localparam int NVEC = 1 << NVARS;

   logic             start;
   logic             target;
   logic             busy;
   logic             m_valid;
   logic             m_ready;
   logic [NVARS-1:0] m_xyz;
   logic             done;
   logic [NVEC-1:0]  mask;
   logic [CNT_W-1:0] count;

   modport master (
      output start, target, m_ready,
      input  busy, m_valid, m_xyz, done, mask, count
   );

   modport slave (
      input  start, target, m_ready,
      output busy, m_valid, m_xyz, done, mask, count
   );
endinterface

// File: rtl/function_3bit_solver.sv
// Inverse solver for f = x | (y & ~z): sweeps all {x,y,z}, streams each vector
// whose f equals the latched target, then pulses done with the minterm mask/count.
module function_3bit_solver #(
   parameter int NVARS = 3,
   parameter int CNT_W = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   function_3bit_solver_if.slave  bus
);
   localparam int NVEC = 1 << NVARS;

   typedef enum logic [1:0] {IDLE, EVAL, OUT, DONE} state_e;

   state_e           state_q;
   logic [NVARS-1:0] idx_q;
   logic             tgt_q;
   logic             busy_q;
   logic             m_valid_q;
   logic [NVARS-1:0] m_xyz_q;
   logic             done_q;
   logic [NVEC-1:0]  mask_q;
   logic [CNT_W-1:0] count_q;

   logic             f_d;
   logic             last_d;
   logic [NVARS-1:0] idx_d;

   assign f_d    = idx_q[2] | (idx_q[1] & ~idx_q[0]);
   assign last_d = &idx_q;
   assign idx_d  = idx_q + NVARS'(1);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         tgt_q     <= 1'b0;
         busy_q    <= 1'b0;
         m_valid_q <= 1'b0;
         m_xyz_q   <= '0;
         done_q    <= 1'b0;
         mask_q    <= '0;
         count_q   <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.start) begin
                  tgt_q   <= bus.target;
                  idx_q   <= '0;
                  mask_q  <= '0;
                  count_q <= '0;
                  busy_q  <= 1'b1;
                  state_q <= EVAL;
               end
            end
            EVAL: begin
               if (f_d == tgt_q) begin
                  mask_q[idx_q] <= 1'b1;
                  count_q       <= count_q + CNT_W'(1);
                  m_xyz_q       <= idx_q;
                  m_valid_q     <= 1'b1;
                  state_q       <= OUT;
               end else if (last_d) begin
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end else begin
                  idx_q <= idx_d;
               end
            end
            OUT: begin
               // m_valid is always high here, so m_ready alone completes the handshake
               if (bus.m_ready) begin
                  m_valid_q <= 1'b0;
                  if (last_d) begin
                     done_q  <= 1'b1;
                     state_q <= DONE;
                  end else begin
                     idx_q   <= idx_d;
                     state_q <= EVAL;
                  end
               end
            end
            DONE: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.busy    = busy_q;
   assign bus.m_valid = m_valid_q;
   assign bus.m_xyz   = m_xyz_q;
   assign bus.done    = done_q;
   assign bus.mask    = mask_q;
   assign bus.count   = count_q;
endmodule

// File: tb/tb_function_3bit_solver.sv
// Directed bench for function_3bit_solver: full sweeps for both targets,
// backpressure, ignored starts, mid-stream reset and IDLE hold.
module tb_function_3bit_solver;
   logic clk = 1'b0;
   logic rst;
   int   n_chk = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   function_3bit_solver_if #(.NVARS(3), .CNT_W(4)) bus ();

   function_3bit_solver #(.NVARS(3), .CNT_W(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] model_mask(input logic t);
      logic [7:0] m;
      logic [2:0] i;
      m = '0;
      for (int k = 0; k < 8; k++) begin
         i = 3'(k);
         m[k] = ((i[2] | (i[1] & ~i[0])) == t);
      end
      return m;
   endfunction

   // One sweep starting from IDLE; start is accepted at edge 0, cycles counted from there.
   task automatic sweep(input logic t, input int stall, input bit poke,
                        input logic [7:0] exp_mask, input int exp_cnt, input int exp_done);
      logic [2:0] got[$];
      int         left, dcyc, k;
      bit         seen_done;
      logic       pv, pr;
      logic [2:0] px;
      bus.target  = t;
      bus.start   = 1'b1;
      bus.m_ready = 1'b1;
      tick();
      bus.start = 1'b0;
      if (poke) bus.target = ~t;
      left = stall; dcyc = -1; seen_done = 0; pv = 0; pr = 0; px = '0;
      for (int c = 1; c <= 40 && !seen_done; c++) begin
         if (pv && !pr) begin
            chk("hold_valid", bus.m_valid, 1);
            chk("hold_xyz", bus.m_xyz, px);
         end
         chk("busy", bus.busy, 1);
         bus.start = poke && (c == 2);
         if (bus.m_valid && left > 0) begin
            bus.m_ready = 1'b0;
            left--;
         end else begin
            bus.m_ready = 1'b1;
         end
         if (bus.m_valid && bus.m_ready) got.push_back(bus.m_xyz);
         pv = bus.m_valid; pr = bus.m_ready; px = bus.m_xyz;
         if (bus.done) begin
            seen_done = 1;
            dcyc = c;
            bus.start = poke;
         end else begin
            tick();
         end
      end
      chk("done_cycle", dcyc, exp_done);
      chk("mask", bus.mask, exp_mask);
      chk("count", bus.count, exp_cnt);
      chk("mask_model", bus.mask, model_mask(t));
      chk("count_pop", bus.count, $countones(model_mask(t)));
      chk("n_match", got.size(), exp_cnt);
      k = 0;
      for (int i = 0; i < 8; i++) begin
         if (exp_mask[i]) begin
            if (k < got.size()) chk("xyz_order", got[k], i);
            k++;
         end
      end
      tick();
      bus.start = 1'b0;
      chk("done_pulse", bus.done, 0);
      chk("idle_busy", bus.busy, 0);
      bus.m_ready = 1'b1;
   endtask

   initial begin
      rst = 1'b1;
      bus.start = 1'b0;
      bus.target = 1'b0;
      bus.m_ready = 1'b1;
      tick();
      tick();
      chk("rst_busy", bus.busy, 0);
      chk("rst_valid", bus.m_valid, 0);
      chk("rst_xyz", bus.m_xyz, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_mask", bus.mask, 0);
      chk("rst_count", bus.count, 0);
      rst = 1'b0;
      tick();

      sweep(1'b1, 0, 1'b0, 8'hF4, 5, 14);
      sweep(1'b0, 0, 1'b0, 8'h0B, 3, 12);
      sweep(1'b1, 5, 1'b0, 8'hF4, 5, 19);
      // starts during EVAL and DONE plus a target change must not disturb the sweep
      sweep(1'b1, 0, 1'b1, 8'hF4, 5, 14);
      sweep(1'b0, 0, 1'b0, 8'h0B, 3, 12);

      tick();
      tick();
      chk("idle_mask", bus.mask, 8'h0B);
      chk("idle_count", bus.count, 3);
      chk("idle_xyz", bus.m_xyz, 3);

      // reset while a match is outstanding
      bus.target = 1'b1;
      bus.start = 1'b1;
      bus.m_ready = 1'b0;
      tick();
      bus.start = 1'b0;
      for (int c = 0; c < 10 && !bus.m_valid; c++) tick();
      chk("pre_rst_valid", bus.m_valid, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      bus.m_ready = 1'b1;
      chk("mid_rst_busy", bus.busy, 0);
      chk("mid_rst_valid", bus.m_valid, 0);
      chk("mid_rst_xyz", bus.m_xyz, 0);
      chk("mid_rst_done", bus.done, 0);
      chk("mid_rst_mask", bus.mask, 0);
      chk("mid_rst_count", bus.count, 0);
      tick();
      chk("mid_rst_idle_done", bus.done, 0);
      sweep(1'b0, 0, 1'b0, 8'h0B, 3, 12);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule
